// File: rtl/cdc_hs_pkg.sv
// Shared types and limits for the four-phase handshake source (and its future sink).
`timescale 1ns/1ps
package cdc_hs_pkg;

  typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL} hs_state_e;

  localparam int HS_SYNC_DP_MIN = 2;

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Local valid/ready port plus far-domain req/ack/data bundle of the handshake source.
// err_o exists only when CDC_HS_TX_TIMEOUT_EN is defined.
`timescale 1ns/1ps
interface cdc_hs_tx_if #(
  parameter int unsigned DW = 32
) ();

  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          req_o;
  logic [DW-1:0] data_o;
  logic          ack_i;
  logic          busy_o;
`ifdef CDC_HS_TX_TIMEOUT_EN
  logic          err_o;
`endif

  // Environment side: local producer and far-domain acknowledger.
  modport master (
    output valid_i,
    output data_i,
    output ack_i,
    input  ready_o,
    input  req_o,
    input  data_o,
    input  busy_o
`ifdef CDC_HS_TX_TIMEOUT_EN
    , input err_o
`endif
  );

  // Handshake source side.
  modport slave (
    input  valid_i,
    input  data_i,
    input  ack_i,
    output ready_o,
    output req_o,
    output data_o,
    output busy_o
`ifdef CDC_HS_TX_TIMEOUT_EN
    , output err_o
`endif
  );

endinterface

// File: rtl/cdc_hs_sync.sv
// 1-bit reset-to-0 flop chain for bringing an asynchronous level into clk_i.
`timescale 1ns/1ps
module cdc_hs_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], d_i};
    end
  end

  assign q_o = chain[DEPTH-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a four-phase req/ack handshake carrying one word out of clk_i.
// Optional per-phase timeout with err_o pulse: define CDC_HS_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned SYNC_DP = 2
`ifdef CDC_HS_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 1024
`endif
) (
  input logic        clk_i,
  input logic        rst_i,
  cdc_hs_tx_if.slave hs
);

  // Depths below the minimum are not metastability-safe; clamp instead of failing.
  localparam int unsigned SYNC_DEPTH =
    (SYNC_DP < unsigned'(HS_SYNC_DP_MIN)) ? unsigned'(HS_SYNC_DP_MIN) : SYNC_DP;

  hs_state_e     state;
  logic          req_q;
  logic          busy_q;
  logic [DW-1:0] data_q;
  logic          ack_s;
  logic          ready_c;
  logic          accept_c;
  logic          timeout_c;

  cdc_hs_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_ack_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (hs.ack_i),
    .q_o   (ack_s)
  );

  // A stale acknowledge still high from the last transfer blocks new words.
  assign ready_c  = !rst_i && (state == HS_IDLE) && !ack_s;
  assign accept_c = hs.valid_i && ready_c;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;
  logic          err_q;

  assign timeout_c = (state != HS_IDLE) && (cnt == CW'(TIMEOUT - 1));

  // Phase timer: restarts on every state change, runs only in REQ/REL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if ((state == HS_IDLE) || timeout_c ||
                 ((state == HS_REQ) && ack_s) ||
                 ((state == HS_REL) && !ack_s)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_c;
    end
  end

  assign hs.err_o = err_q;
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= HS_IDLE;
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
    end else begin
      unique case (state)
        HS_IDLE: begin
          if (accept_c) begin
            data_q <= hs.data_i;
            req_q  <= 1'b1;
            busy_q <= 1'b1;
            state  <= HS_REQ;
          end
        end
        HS_REQ: begin
          if (timeout_c) begin
            req_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= HS_IDLE;
          end else if (ack_s) begin
            req_q <= 1'b0;
            state <= HS_REL;
          end
        end
        HS_REL: begin
          if (timeout_c || !ack_s) begin
            busy_q <= 1'b0;
            state  <= HS_IDLE;
          end
        end
        default: begin
          req_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= HS_IDLE;
        end
      endcase
    end
  end

  assign hs.ready_o = ready_c;
  assign hs.req_o   = req_q;
  assign hs.data_o  = data_q;
  assign hs.busy_o  = busy_q;

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

- Source end of a four-phase req/ack handshake that moves a data word out of this clock domain.
- Accepts a word on a local valid/ready port, holds it stable on `data_o`, raises `req_o`, and waits for the far side's `ack_i`.
- `ack_i` is asynchronous, so it passes through an internal reset-to-0 flop chain before the FSM uses it.
- The far-end receiver synchronizes `req_o` with its own flop chain and samples `data_o`.

## Interface
- `DW`, 32, data word width.
- `SYNC_DP`, 2, number of synchronizer flops on `ack_i`; legal values ≥2.
- `TIMEOUT`, 1024, cycle limit per handshake phase. Used only with the timeout feature; legal values ≥4.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `valid_i`  in  1  local word offered.
- `ready_o`  out  1  block can accept a word.
- `data_i`  in  DW  local word.
- `req_o`  out  1  request to the far domain; driven directly from a flop.
- `data_o`  out  DW  held word; stable whenever `req_o` is 1.
- `ack_i`  in  1  acknowledge from the far domain; asynchronous.
- `busy_o`  out  1  a handshake is in progress (state ≠ IDLE).
- `err_o`  out  1  timeout pulse. Present only when `CDC_HS_TX_TIMEOUT_EN` is defined.

## Operation
- `ack_s` is `ack_i` delayed through `SYNC_DP` flops. The FSM uses only `ack_s`.
- **IDLE:**
  - `ready_o` = !`ack_s`, so a stale acknowledge blocks new transfers.
  - When `valid_i`&&`ready_o`: capture `data_i` into `data_o`, set `req_o`=1, go to REQ.
- **REQ:** hold `req_o`=1 and `data_o`. On `ack_s`=1: `req_o`=0, go to REL.
- **REL:** hold `req_o`=0. On `ack_s`=0: go to IDLE.
- `data_o` changes only on an accept. It holds its value through REL and IDLE.
- `ready_o`=0 in REQ and REL. `valid_i` is ignored outside IDLE.
- Reset clears:
  - the state (to IDLE), `req_o`, `data_o`, `busy_o`, `err_o`;
  - all synchronizer flops;
  - the timeout counter.
- `ready_o` is 0 during reset.
- Reset mid-handshake drops `req_o` on the next edge. The far side sees an aborted request, and this is legal.

## Timing
- Accept at edge T → `req_o`=1 and `busy_o`=1 after edge T.
- `ack_i` rising before edge A → `ack_s`=1 after edge A+SYNC_DP−1 → `req_o`=0 after edge A+SYNC_DP.
- The falling side of the handshake uses the same delay: `ack_i` low before edge F → state is IDLE after edge F+SYNC_DP.
- When `ack_s`=0 in IDLE, `ready_o` is high in that same cycle.
- Minimum round trip in this domain: 2·SYNC_DP+2 cycles per word, plus far-side latency.
- Back-to-back: with `valid_i` held high, the next accept happens in the first IDLE cycle.

## Configuration
- `CDC_HS_TX_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT)`-bit counter clears on every state change and increments each cycle while in REQ or REL.
  - When it reaches TIMEOUT−1: force `req_o`=0, go to IDLE, and pulse `err_o` high for exactly one cycle.
  - In IDLE, `ack_s` still gates `ready_o`.
- Not defined:
  - No counter and no `err_o` port.
  - REQ and REL wait indefinitely.

## Structure
- Package `cdc_hs_pkg` holds:
  - `typedef enum logic [1:0] {HS_IDLE, HS_REQ, HS_REL} hs_state_e`;
  - `localparam int HS_SYNC_DP_MIN = 2`.
- Sub-module `cdc_hs_sync`: a `SYNC_DP`-deep, 1-bit, synchronous active-high reset flop chain. The same chain is reused by the future receive side.

## Test plan
- Single word:
  - Stimulus: DW=32, SYNC_DP=2, accept 0xDEADBEEF at edge 5; ack_i rises at edge 12 and falls at edge 20.
  - Required: `req_o` is 1 from edge 5 to edge 14; `data_o`=0xDEADBEEF until the next accept; IDLE and `ready_o`=1 after edge 22.
- Back-to-back: with `valid_i` held high for 3 words (1, 2, 3) and the far-side model acking after 3 cycles, `data_o` sequence is 1, 2, 3 with no missed word or duplicate.
- Stale acknowledge: `ack_i` held high out of reset → `ready_o` stays 0 and `valid_i` is ignored; `ack_i` low → `ready_o`=1 after SYNC_DP edges.
- Reset mid-REQ: `rst_i` asserted one cycle while `req_o`=1 → `req_o`=0, `busy_o`=0, `data_o`=0 after that edge.
- Timeout (macro on, TIMEOUT=8): `ack_i` never rises → `err_o` high for one cycle, 8 cycles after accept; `req_o`=0; IDLE.
- Macro off: ack delayed 5000 cycles → no error, and the handshake completes normally.
